// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the round-robin hold arbiter slice.
//   arb_state_e : FSM state encoding (IDLE, GRANT)
//   clog2_min1  : ceil(log2(n)) clamped to a minimum of 1, so vectors sized
//                 from small parameters never collapse to zero width
// ---------------------------------------------------------------------------
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational circular picker. Returns the first set bit of req scanning
// from index ptr upward and wrapping to 0.
//   req  : request vector
//   ptr  : index with the highest priority this cycle
//   pick : one-hot selection (all-zero when req is zero)
//   idx  : binary index of pick (0 when req is zero)
// ---------------------------------------------------------------------------
module rr_pick
    import arb_pkg::*;
#(
    parameter  int REQUESTERS = 4,
    localparam int IDW        = clog2_min1(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] req,
    input  logic [IDW-1:0]        ptr,
    output logic [REQUESTERS-1:0] pick,
    output logic [IDW-1:0]        idx
);

    logic [REQUESTERS-1:0] mask;
    logic [REQUESTERS-1:0] masked;
    logic [REQUESTERS-1:0] m_pick;
    logic [REQUESTERS-1:0] u_pick;
    logic [IDW-1:0]        m_idx;
    logic [IDW-1:0]        u_idx;

    // Keep only the requesters at or above ptr; these outrank the wrapped
    // requesters below ptr.
    always_comb begin
        mask = '0;
        for (int i = 0; i < REQUESTERS; i++) begin
            mask[i] = (IDW'(i) >= ptr);
        end
    end

    assign masked = req & mask;

    // Two lowest-index-wins pickers, one on the masked vector and one on the
    // raw vector. The scan runs downward so the lowest set bit is the last
    // one written.
    always_comb begin
        m_pick = '0;
        m_idx  = '0;
        u_pick = '0;
        u_idx  = '0;
        for (int i = REQUESTERS - 1; i >= 0; i--) begin
            if (masked[i]) begin
                m_pick    = '0;
                m_pick[i] = 1'b1;
                m_idx     = IDW'(i);
            end
            if (req[i]) begin
                u_pick    = '0;
                u_pick[i] = 1'b1;
                u_idx     = IDW'(i);
            end
        end
    end

    // Nothing at or above ptr means the winner is the lowest index below ptr,
    // which is exactly what the unmasked picker found.
    assign pick = (|m_pick) ? m_pick : u_pick;
    assign idx  = (|m_pick) ? m_idx  : u_idx;

endmodule

// File: rtl/rr_hold_arbiter.sv
// ---------------------------------------------------------------------------
// rr_hold_arbiter
// Round-robin arbiter with a registered one-hot grant. The owner keeps the
// grant until it pulses done, drops its request, or has held it for MAX_HOLD
// cycles (MAX_HOLD = 0 disables the limit). On release the next owner is
// picked in the same cycle, so handoffs have no idle bubble.
//   clk           : rising-edge clock
//   reset         : synchronous active-high reset
//   req_i         : one request bit per requester
//   done_i        : owner's transfer-finished pulse
//   grant_o       : registered one-hot grant, zero when idle
//   grant_id_o    : binary index of the owner, 0 when idle
//   grant_valid_o : high whenever grant_o is non-zero
// ---------------------------------------------------------------------------
module rr_hold_arbiter
    import arb_pkg::*;
#(
    parameter  int REQUESTERS = 4,
    parameter  int MAX_HOLD   = 16,
    localparam int IDW        = clog2_min1(REQUESTERS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [REQUESTERS-1:0] req_i,
    input  logic                  done_i,
    output logic [REQUESTERS-1:0] grant_o,
    output logic [IDW-1:0]        grant_id_o,
    output logic                  grant_valid_o
);

    localparam int             CW        = clog2_min1(MAX_HOLD + 1);
    localparam logic [CW-1:0]  HOLD_LAST = (MAX_HOLD == 0) ? '0 : CW'(MAX_HOLD - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(REQUESTERS - 1);

    arb_state_e            state, state_nxt;
    logic [IDW-1:0]        ptr, ptr_nxt;
    logic [CW-1:0]         cnt, cnt_nxt;
    logic [REQUESTERS-1:0] grant_nxt;
    logic [IDW-1:0]        id_nxt;
    logic                  valid_nxt;

    logic                  owner_req;
    logic                  timeout;
    logic                  release_now;
    logic [IDW-1:0]        ptr_rel;
    logic [IDW-1:0]        pick_ptr;
    logic [REQUESTERS-1:0] pick;
    logic [IDW-1:0]        pick_idx;

    // The grant is one-hot, so masking req_i with it tells us whether the
    // owner still requests without indexing by a possibly narrow id.
    assign owner_req   = |(req_i & grant_o);
    assign timeout     = (MAX_HOLD != 0) && (cnt == HOLD_LAST);
    assign release_now = (state == GRANT) && (done_i || !owner_req || timeout);

    // Priority moves just past the releasing owner, which puts the owner
    // itself last in line for the re-pick.
    assign ptr_rel  = (grant_id_o == LAST_ID) ? '0 : grant_id_o + IDW'(1);
    assign pick_ptr = (state == GRANT) ? ptr_rel : ptr;

    rr_pick #(
        .REQUESTERS(REQUESTERS)
    ) u_pick (
        .req  (req_i),
        .ptr  (pick_ptr),
        .pick (pick),
        .idx  (pick_idx)
    );

    // State and output registers. Reset takes priority over everything and
    // puts requester 0 back at the top of the rotation.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            ptr           <= '0;
            cnt           <= '0;
            grant_o       <= '0;
            grant_id_o    <= '0;
            grant_valid_o <= '0;
        end else begin
            state         <= state_nxt;
            ptr           <= ptr_nxt;
            cnt           <= cnt_nxt;
            grant_o       <= grant_nxt;
            grant_id_o    <= id_nxt;
            grant_valid_o <= valid_nxt;
        end
    end

    // Next-state logic. IDLE grants the first picked requester. GRANT holds
    // the owner, counting hold cycles, until a release, then either hands
    // straight to the next pick or drops back to IDLE when nobody requests.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        grant_nxt = grant_o;
        id_nxt    = grant_id_o;
        valid_nxt = grant_valid_o;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (|req_i) begin
                    state_nxt = GRANT;
                    grant_nxt = pick;
                    id_nxt    = pick_idx;
                    valid_nxt = 1'b1;
                end else begin
                    grant_nxt = '0;
                    id_nxt    = '0;
                    valid_nxt = 1'b0;
                end
            end

            GRANT: begin
                if (release_now) begin
                    ptr_nxt = ptr_rel;
                    cnt_nxt = '0;
                    if (|pick) begin
                        grant_nxt = pick;
                        id_nxt    = pick_idx;
                        valid_nxt = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        id_nxt    = '0;
                        valid_nxt = 1'b0;
                    end
                end else if (MAX_HOLD != 0) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end

            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
                id_nxt    = '0;
                valid_nxt = 1'b0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Structural invariants of the grant outputs.
    a_grant_onehot0 : assert property (@(posedge clk) disable iff (reset)
        $onehot0(grant_o));

    a_valid_matches : assert property (@(posedge clk) disable iff (reset)
        grant_valid_o == (|grant_o));

    a_grant_had_req : assert property (@(posedge clk) disable iff (reset)
        (grant_o & ~$past(req_i)) == '0);

endmodule

// File: tb/tb_rr_hold_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_hold_arbiter
// Directed bench for rr_hold_arbiter with REQUESTERS=4. The main instance
// uses MAX_HOLD=4; a second instance uses MAX_HOLD=0 (unlimited hold).
// ---------------------------------------------------------------------------
module tb_rr_hold_arbiter;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] gid;
    logic       gvalid;

    logic [3:0] req2;
    logic       done2;
    logic [3:0] grant2;
    logic [1:0] gid2;
    logic       gvalid2;

    int checks;
    int errors;

    rr_hold_arbiter #(
        .REQUESTERS(4),
        .MAX_HOLD  (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req),
        .done_i       (done),
        .grant_o      (grant),
        .grant_id_o   (gid),
        .grant_valid_o(gvalid)
    );

    rr_hold_arbiter #(
        .REQUESTERS(4),
        .MAX_HOLD  (0)
    ) dut_nolimit (
        .clk          (clk),
        .reset        (reset),
        .req_i        (req2),
        .done_i       (done2),
        .grant_o      (grant2),
        .grant_id_o   (gid2),
        .grant_valid_o(gvalid2)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one cycle of inputs, let the edge happen, and return 1 time unit
    // later so outputs are sampled away from the edge.
    task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic d);
        reset = rst;
        req   = r;
        done  = d;
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check, reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [3:0] exp_g;
        logic [1:0] exp_id;

        checks = 0;
        errors = 0;
        reset  = 1'b1;
        req    = 4'b0000;
        done   = 1'b0;
        req2   = 4'b0000;
        done2  = 1'b0;

        // 1: reset held two cycles with everyone requesting.
        applyStimulus(1'b1, 4'b1111, 1'b0);
        checkOutput("rst_c1_grant", 32'(grant), 32'h0);
        checkOutput("rst_c1_valid", 32'(gvalid), 32'h0);
        applyStimulus(1'b1, 4'b1111, 1'b0);
        checkOutput("rst_c2_grant", 32'(grant), 32'h0);
        checkOutput("rst_c2_id", 32'(gid), 32'h0);
        applyStimulus(1'b0, 4'b1111, 1'b0);
        checkOutput("first_grant", 32'(grant), 32'h1);
        checkOutput("first_id", 32'(gid), 32'h0);
        checkOutput("first_valid", 32'(gvalid), 32'h1);

        // 2: done every cycle rotates 0001 -> 0010 -> 0100 -> 1000 -> 0001.
        for (int i = 1; i <= 4; i++) begin
            exp_id = 2'(i % 4);
            exp_g  = 4'b0001 << exp_id;
            applyStimulus(1'b0, 4'b1111, 1'b1);
            checkOutput($sformatf("done_rot%0d_grant", i), 32'(grant), 32'(exp_g));
            checkOutput($sformatf("done_rot%0d_id", i), 32'(gid), 32'(exp_id));
            checkOutput($sformatf("done_rot%0d_valid", i), 32'(gvalid), 32'h1);
        end

        // 3: two requesters, timeout rotation every 4 cycles.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 9; i++) begin
            exp_g  = (i < 4) ? 4'b0001 : (i < 8) ? 4'b0010 : 4'b0001;
            exp_id = (i < 4) ? 2'd0 : (i < 8) ? 2'd1 : 2'd0;
            applyStimulus(1'b0, 4'b0011, 1'b0);
            checkOutput($sformatf("tmo_c%0d_grant", i), 32'(grant), 32'(exp_g));
            checkOutput($sformatf("tmo_c%0d_id", i), 32'(gid), 32'(exp_id));
        end

        // 4a: owner 2 drops its request, 3 is next in rotation.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        checkOutput("own2_grant", 32'(grant), 32'h4);
        applyStimulus(1'b0, 4'b1011, 1'b0);
        checkOutput("drop2_grant", 32'(grant), 32'h8);
        checkOutput("drop2_id", 32'(gid), 32'h3);

        // 4b: owner 2 drops and nobody else requests -> idle.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        applyStimulus(1'b0, 4'b0000, 1'b0);
        checkOutput("idle_grant", 32'(grant), 32'h0);
        checkOutput("idle_valid", 32'(gvalid), 32'h0);
        checkOutput("idle_id", 32'(gid), 32'h0);
        // done while idle must not create a grant.
        applyStimulus(1'b0, 4'b0000, 1'b1);
        checkOutput("idle_done_grant", 32'(grant), 32'h0);
        checkOutput("idle_done_valid", 32'(gvalid), 32'h0);

        // 5: sole requester survives timeouts with no bubble; the unlimited
        // instance keeps its first owner indefinitely.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        req2 = 4'b0011;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 4'b0100, 1'b0);
            checkOutput($sformatf("sole_c%0d_grant", i), 32'(grant), 32'h4);
            checkOutput($sformatf("sole_c%0d_id", i), 32'(gid), 32'h2);
            checkOutput($sformatf("nolim_c%0d_grant", i), 32'(grant2), 32'h1);
        end
        // Sole requester signalling done is re-granted in place.
        applyStimulus(1'b0, 4'b0100, 1'b1);
        checkOutput("sole_done_grant", 32'(grant), 32'h4);
        checkOutput("sole_done_valid", 32'(gvalid), 32'h1);
        req2 = 4'b0000;

        // 6: reset while owner=3, ptr=3; afterwards requester 0 wins.
        applyStimulus(1'b1, 4'b0000, 1'b0);
        applyStimulus(1'b0, 4'b0100, 1'b0);
        applyStimulus(1'b0, 4'b1000, 1'b0);
        checkOutput("own3_grant", 32'(grant), 32'h8);
        applyStimulus(1'b1, 4'b1001, 1'b0);
        checkOutput("midrst_grant", 32'(grant), 32'h0);
        checkOutput("midrst_valid", 32'(gvalid), 32'h0);
        applyStimulus(1'b0, 4'b1001, 1'b0);
        checkOutput("postrst_grant", 32'(grant), 32'h1);
        checkOutput("postrst_id", 32'(gid), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
